xor_cipher_sequencer: RTL and testbench

Control FSM that sequences the serial XOR cipher datapath (key deserializer, message deserializer, key assembler, XOR stage, serializer) for one host. It accepts a serial bit stream from the host over a valid/ready handshake, steers those bits into the key or message load path, waits for the datapath done flag, then forwards the ciphertext bits back to the host. It sits between the host pins and the cipher datapath and runs on the datapath's (divided) clock.

---
 rtl/xor_seq_pkg.sv | 21 ++
 rtl/xor_seq_watchdog.sv | 28 ++
 rtl/xor_cipher_sequencer.sv | 171 +++++++++++++++++
 tb/tb_xor_cipher_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_seq_pkg.sv
// Shared state encoding and default sizing for the XOR cipher sequencer.
package xor_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KEY,
    LOAD_MSG,
    WAIT_DONE,
    DRAIN,
    ERROR
  } seqState_t;

  localparam int unsigned DEF_KEY_SIZE = 4;
  localparam int unsigned DEF_MSG_SIZE = 8;
  localparam int unsigned DEF_TIMEOUT  = 64;

  function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/xor_seq_watchdog.sv
// WAIT_DONE watchdog: clears while idle, counts while enabled, flags the
// cycle whose edge completes TIMEOUT counted cycles.
module xor_seq_watchdog
  import xor_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iClear,
  input  logic iCount,
  output logic oTerm
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] cnt;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst)       cnt <= '0;
    else if (iClear) cnt <= '0;
    else if (iCount) cnt <= cnt + 1'b1;
  end

  assign oTerm = iCount && (cnt == LAST);

endmodule

// File: rtl/xor_cipher_sequencer.sv
// Control FSM steering host serial bits into the XOR cipher datapath and
// draining ciphertext back. Watchdog/ERROR path built only with XOR_SEQ_WATCHDOG_EN.
module xor_cipher_sequencer
  import xor_seq_pkg::*;
#(
  parameter int unsigned KEY_SIZE = DEF_KEY_SIZE,
  parameter int unsigned MSG_SIZE = DEF_MSG_SIZE,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iStart,
  input  logic iNew_key,
  input  logic iAbort,
  input  logic iBit_valid,
  input  logic iSerial_in,
  output logic oBit_ready,
  output logic oEn,
  output logic oData_in,
  output logic oLoad_key,
  output logic oLoad_msg,
  input  logic iDone_flag,
  input  logic iData_out,
  output logic oOut_valid,
  output logic oOut_bit,
  output logic oBusy,
  output logic oDone,
  output logic oError
);

  localparam int unsigned CNT_W = $clog2(maxOf(KEY_SIZE, MSG_SIZE) + 1);
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_SIZE - 1);
  localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_SIZE - 1);
  localparam logic [CNT_W-1:0] MSG_FULL = CNT_W'(MSG_SIZE);

  seqState_t       state, stateNext;
  logic [CNT_W-1:0] bitCnt, bitCntNext;
  logic keyValid, keyValidNext;
  logic enPulse, enPulseNext;
  logic dataNext, loadKeyNext, loadMsgNext;
  logic outValidNext, outBitNext, doneNext;
  logic accept, wdTerm;

  assign oBit_ready = (state == LOAD_KEY) || (state == LOAD_MSG);
  assign oBusy      = (state != IDLE);
  assign oEn        = enPulse || (state == WAIT_DONE) || (state == DRAIN);
  assign accept     = iBit_valid && oBit_ready;

`ifdef XOR_SEQ_WATCHDOG_EN
  logic errReg;

  xor_seq_watchdog #(.TIMEOUT(TIMEOUT)) uWatchdog (
    .iClk   (iClk),
    .iRst   (iRst),
    .iClear (state != WAIT_DONE),
    .iCount (state == WAIT_DONE),
    .oTerm  (wdTerm)
  );

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst)                                          errReg <= 1'b0;
    else if (state == WAIT_DONE && stateNext == ERROR)  errReg <= 1'b1;
    else if (state == IDLE && iStart && !iAbort)        errReg <= 1'b0;
  end

  assign oError = errReg;
`else
  assign wdTerm = 1'b0;
  assign oError = 1'b0;
`endif

  always_comb begin
    stateNext    = state;
    bitCntNext   = bitCnt;
    keyValidNext = keyValid;
    enPulseNext  = 1'b0;
    dataNext     = oData_in;
    loadKeyNext  = 1'b0;
    loadMsgNext  = 1'b0;
    outValidNext = 1'b0;
    outBitNext   = oOut_bit;
    doneNext     = 1'b0;

    if (accept) begin
      dataNext    = iSerial_in;
      enPulseNext = 1'b1;
      loadKeyNext = (state == LOAD_KEY);
      loadMsgNext = (state == LOAD_MSG);
      bitCntNext  = bitCnt + 1'b1;
    end

    unique case (state)
      IDLE: if (iStart) stateNext = (iNew_key || !keyValid) ? LOAD_KEY : LOAD_MSG;
      LOAD_KEY: if (accept && bitCnt == KEY_LAST) begin
        stateNext    = LOAD_MSG;
        bitCntNext   = '0;
        keyValidNext = 1'b1;
      end
      LOAD_MSG: if (accept && bitCnt == MSG_LAST) begin
        stateNext  = WAIT_DONE;
        bitCntNext = '0;
      end
      // First ciphertext bit is captured on the done edge itself
      WAIT_DONE: if (iDone_flag) begin
        stateNext    = DRAIN;
        outValidNext = 1'b1;
        outBitNext   = iData_out;
        bitCntNext   = CNT_W'(1);
        doneNext     = (MSG_SIZE == 1);
      end else if (wdTerm) begin
        stateNext    = ERROR;
        keyValidNext = 1'b0;
      end
      // One tail cycle after the last capture keeps oBusy high alongside oDone
      DRAIN: if (bitCnt != MSG_FULL) begin
        outValidNext = 1'b1;
        outBitNext   = iData_out;
        bitCntNext   = bitCnt + 1'b1;
        doneNext     = (bitCnt == MSG_LAST);
      end else begin
        stateNext  = IDLE;
        bitCntNext = '0;
      end
      ERROR: begin
        stateNext    = IDLE;
        keyValidNext = 1'b0;
      end
      default: stateNext = IDLE;
    endcase

    if (iAbort) begin
      stateNext    = IDLE;
      bitCntNext   = '0;
      keyValidNext = 1'b0;
      enPulseNext  = 1'b0;
      dataNext     = oData_in;
      loadKeyNext  = 1'b0;
      loadMsgNext  = 1'b0;
      outValidNext = 1'b0;
      outBitNext   = oOut_bit;
      doneNext     = 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state      <= IDLE;
      bitCnt     <= '0;
      keyValid   <= 1'b0;
      enPulse    <= 1'b0;
      oData_in   <= 1'b0;
      oLoad_key  <= 1'b0;
      oLoad_msg  <= 1'b0;
      oOut_valid <= 1'b0;
      oOut_bit   <= 1'b0;
      oDone      <= 1'b0;
    end else begin
      state      <= stateNext;
      bitCnt     <= bitCntNext;
      keyValid   <= keyValidNext;
      enPulse    <= enPulseNext;
      oData_in   <= dataNext;
      oLoad_key  <= loadKeyNext;
      oLoad_msg  <= loadMsgNext;
      oOut_valid <= outValidNext;
      oOut_bit   <= outBitNext;
      oDone      <= doneNext;
    end
  end

endmodule

// File: tb/tb_xor_cipher_sequencer.sv
// Directed bench for xor_cipher_sequencer: a transaction-level expectation
// script checked against every output each cycle, plus literal tallies.
module tb_xor_cipher_sequencer;

  localparam int KS = 4;
  localparam int MS = 8;
  localparam int TO = 64;

  logic iClk, iRst, iStart, iNew_key, iAbort, iBit_valid, iSerial_in;
  logic iDone_flag, iData_out;
  logic oBit_ready, oEn, oData_in, oLoad_key, oLoad_msg;
  logic oOut_valid, oOut_bit, oBusy, oDone, oError;

  xor_cipher_sequencer #(.KEY_SIZE(KS), .MSG_SIZE(MS), .TIMEOUT(TO)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iNew_key(iNew_key),
    .iAbort(iAbort), .iBit_valid(iBit_valid), .iSerial_in(iSerial_in),
    .oBit_ready(oBit_ready), .oEn(oEn), .oData_in(oData_in),
    .oLoad_key(oLoad_key), .oLoad_msg(oLoad_msg), .iDone_flag(iDone_flag),
    .iData_out(iData_out), .oOut_valid(oOut_valid), .oOut_bit(oOut_bit),
    .oBusy(oBusy), .oDone(oDone), .oError(oError)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  int checks = 0;
  int failures = 0;

  // Model: what the host has established so far, in protocol terms
  logic mKeyValid, mError, mData, mOutBit;

  // Tallies of observed DUT activity, checked against hand-computed literals
  int nLK = 0, nLM = 0, nOV = 0, nDone = 0;
  logic [KS-1:0] colKey;
  logic [MS-1:0] colMsg, colOut;
  int bLK, bLM, bOV, bDone;

  task automatic cmp1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmpV(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmpAll(input logic rdy, input logic bsy, input logic en,
                        input logic lk, input logic lm, input logic ov, input logic dn);
    cmp1("oBit_ready", oBit_ready, rdy);
    cmp1("oBusy", oBusy, bsy);
    cmp1("oEn", oEn, en);
    cmp1("oLoad_key", oLoad_key, lk);
    cmp1("oLoad_msg", oLoad_msg, lm);
    cmp1("oData_in", oData_in, mData);
    cmp1("oOut_valid", oOut_valid, ov);
    cmp1("oOut_bit", oOut_bit, mOutBit);
    cmp1("oDone", oDone, dn);
    cmp1("oError", oError, mError);
    if (oLoad_key)  begin nLK++; colKey = {colKey[KS-2:0], oData_in}; end
    if (oLoad_msg)  begin nLM++; colMsg = {colMsg[MS-2:0], oData_in}; end
    if (oOut_valid) begin nOV++; colOut = {colOut[MS-2:0], oOut_bit}; end
    if (oDone) nDone++;
  endtask

  // One clock: inputs already applied; check the window after the edge
  task automatic step(input logic rdy, input logic bsy, input logic en,
                      input logic lk, input logic lm, input logic ov, input logic dn);
    @(posedge iClk);
    @(negedge iClk);
    cmpAll(rdy, bsy, en, lk, lm, ov, dn);
  endtask

  task automatic snap();
    bLK = nLK; bLM = nLM; bOV = nOV; bDone = nDone;
  endtask

  task automatic doStart(input logic newKey, output logic goKey);
    iStart = 1'b1;
    iNew_key = newKey;
    goKey = newKey || !mKeyValid;
    mError = 1'b0;
    step(1, 1, 0, 0, 0, 0, 0);
    iStart = 1'b0;
  endtask

  task automatic sendBit(input logic b, input logic isKey, input logic last,
                         input logic gap, input logic abortIt);
    if (gap) begin
      iBit_valid = 1'b0;
      step(1, 1, 0, 0, 0, 0, 0);
    end
    iBit_valid = 1'b1;
    iSerial_in = b;
    iAbort = abortIt;
    if (abortIt) begin
      mKeyValid = 1'b0;
      step(0, 0, 0, 0, 0, 0, 0);
    end else begin
      mData = b;
      if (isKey && last) mKeyValid = 1'b1;
      step(!(last && !isKey), 1, 1, isKey, !isKey, 0, 0);
    end
    iBit_valid = 1'b0;
    iAbort = 1'b0;
  endtask

  task automatic sendKey(input logic [KS-1:0] k);
    for (int i = KS - 1; i >= 0; i--) sendBit(k[i], 1'b1, i == 0, 1'b0, 1'b0);
  endtask

  task automatic sendMsg(input logic [MS-1:0] m, input logic gap, input logic abortLast);
    for (int i = MS - 1; i >= 0; i--) sendBit(m[i], 1'b0, i == 0, gap, abortLast && i == 0);
  endtask

  task automatic drain(input int nWait, input logic [MS-1:0] dout);
    iDone_flag = 1'b0;
    for (int w = 0; w < nWait; w++) step(0, 1, 1, 0, 0, 0, 0);
    iDone_flag = 1'b1;
    for (int i = MS - 1; i >= 0; i--) begin
      iData_out = dout[i];
      mOutBit = dout[i];
      step(0, 1, 1, 0, 0, 1, i == 0);
      iDone_flag = 1'b0;
    end
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic txn(input logic newKey, input logic [KS-1:0] k, input logic [MS-1:0] m,
                     input logic gap, input int nWait, input logic [MS-1:0] dout);
    logic goKey;
    doStart(newKey, goKey);
    if (goKey) sendKey(k);
    sendMsg(m, gap, 1'b0);
    drain(nWait, dout);
  endtask

  initial begin
    logic goKey;
    iRst = 1'b0; iStart = 1'b0; iNew_key = 1'b0; iAbort = 1'b0;
    iBit_valid = 1'b0; iSerial_in = 1'b0; iDone_flag = 1'b0; iData_out = 1'b0;
    mKeyValid = 1'b0; mError = 1'b0; mData = 1'b0; mOutBit = 1'b0;
    colKey = '0; colMsg = '0; colOut = '0;

    @(negedge iClk);
    cmpAll(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    iRst = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);

    // New key 1010, message C3, done three cycles after the last bit
    snap();
    txn(1'b1, 4'b1010, 8'hC3, 1'b0, 3, 8'h5A);
    cmpV("t1_key_pulses", nLK - bLK, 4);
    cmpV("t1_msg_pulses", nLM - bLM, 8);
    cmpV("t1_key_bits", int'(colKey), 'hA);
    cmpV("t1_msg_bits", int'(colMsg), 'hC3);
    cmpV("t1_out_valid", nOV - bOV, 8);
    cmpV("t1_out_bits", int'(colOut), 'h5A);
    cmpV("t1_done", nDone - bDone, 1);

    // Back-to-back, key reused: straight to message load
    snap();
    txn(1'b0, 4'b0000, 8'h96, 1'b0, 0, 8'hF0);
    cmpV("t2_key_pulses", nLK - bLK, 0);
    cmpV("t2_msg_bits", int'(colMsg), 'h96);
    cmpV("t2_out_bits", int'(colOut), 'hF0);
    cmpV("t2_done", nDone - bDone, 1);

    // Valid toggling every other cycle during message load
    snap();
    txn(1'b0, 4'b0000, 8'h3C, 1'b1, 1, 8'h81);
    cmpV("t3_msg_pulses", nLM - bLM, 8);
    cmpV("t3_msg_bits", int'(colMsg), 'h3C);

    // Abort coincident with the last message bit
    snap();
    doStart(1'b0, goKey);
    sendMsg(8'hFF, 1'b0, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0);
    cmpV("t4_msg_pulses", nLM - bLM, 7);
    cmpV("t4_no_done", nDone - bDone, 0);
    cmpV("t4_no_out", nOV - bOV, 0);

    // Key was invalidated by the abort, so a reuse request reloads the key
    snap();
    txn(1'b0, 4'b0110, 8'h01, 1'b0, 2, 8'h0F);
    cmpV("t5_key_pulses", nLK - bLK, 4);
    cmpV("t5_key_bits", int'(colKey), 'h6);

    // Reset pulse in the middle of message load
    doStart(1'b0, goKey);
    for (int i = 0; i < 3; i++) sendBit(i[0], 1'b0, 1'b0, 1'b0, 1'b0);
    iRst = 1'b0;
    #1;
    mKeyValid = 1'b0; mError = 1'b0; mData = 1'b0; mOutBit = 1'b0;
    cmpAll(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    iRst = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);
    snap();
    txn(1'b0, 4'b1100, 8'h5A, 1'b0, 0, 8'hA5);
    cmpV("t6_key_pulses", nLK - bLK, 4);
    cmpV("t6_key_bits", int'(colKey), 'hC);

    // Done never arrives
    doStart(1'b0, goKey);
    sendMsg(8'hA5, 1'b0, 1'b0);
`ifdef XOR_SEQ_WATCHDOG_EN
    for (int i = 1; i < TO; i++) step(0, 1, 1, 0, 0, 0, 0);
    mError = 1'b1;
    mKeyValid = 1'b0;
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    cmpV("t7_error_sticky", int'(oError), 1);
`else
    for (int i = 0; i < TO + 36; i++) step(0, 1, 1, 0, 0, 0, 0);
    iAbort = 1'b1;
    mKeyValid = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0);
    iAbort = 1'b0;
`endif
    snap();
    doStart(1'b0, goKey);
    cmpV("t7_error_cleared", int'(oError), 0);
    sendKey(4'b0011);
    sendMsg(8'h42, 1'b0, 1'b0);
    drain(0, 8'h24);
    cmpV("t7_key_pulses", nLK - bLK, 4);
    cmpV("t7_done", nDone - bDone, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule
